// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the phase sequencer, display and score blocks.
package game_pkg;

  localparam int unsigned LEVEL_W = 5;
  localparam int unsigned SECS_W  = 6;

  localparam int unsigned PRELIM_SECS_DEF = 3;
  localparam int unsigned PLAY_SECS_DEF   = 20;
  localparam int unsigned ANSWER_SECS_DEF = 10;
  localparam int unsigned POST_SECS_DEF   = 3;
  localparam int unsigned MAX_LEVEL_DEF   = 10;

  typedef enum logic [2:0] {
    StIdle,
    StPrelim,
    StPlay,
    StAnswer,
    StPost,
    StDone
  } state_e;

endpackage

// File: rtl/game_phase_sequencer_if.sv
// Control/status bundle between the game-flow sequencer and its surroundings.
interface game_phase_sequencer_if;
  import game_pkg::*;

  logic               start;
  logic               Clk1Hz;
  logic               answerSubmit;
  logic               prelimPeriod;
  logic               answerPeriod;
  logic               postPeriod;
  logic               levelChng;
  logic [LEVEL_W-1:0] level;
  logic [SECS_W-1:0]  secondsLeft;
  logic               periodStart;
  logic               gameOver;

  modport master (
    output start, Clk1Hz, answerSubmit,
    input  prelimPeriod, answerPeriod, postPeriod, levelChng, level, secondsLeft,
           periodStart, gameOver
  );

  modport slave (
    input  start, Clk1Hz, answerSubmit,
    output prelimPeriod, answerPeriod, postPeriod, levelChng, level, secondsLeft,
           periodStart, gameOver
  );

endinterface

// File: rtl/period_timer.sv
// Loadable down-counter advanced by the 1 Hz tick; expire flags the tick that ends a period.
module period_timer
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SECS_W-1:0] load_val,
  input  logic              tick,
  output logic [SECS_W-1:0] count,
  output logic              expire
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count > SECS_W'(1))) begin
      count <= count - SECS_W'(1);
    end
  end

  // Count never rests at 1 outside a timed state, so no state qualification is needed here.
  assign expire = tick && (count == SECS_W'(1));

endmodule

// File: rtl/game_phase_sequencer.sv
// Game-flow FSM: prelim countdown, symbol play, answer entry and result display per level.
module game_phase_sequencer
  import game_pkg::*;
#(
  parameter int unsigned PRELIM_SECS = PRELIM_SECS_DEF,
  parameter int unsigned PLAY_SECS   = PLAY_SECS_DEF,
  parameter int unsigned ANSWER_SECS = ANSWER_SECS_DEF,
  parameter int unsigned POST_SECS   = POST_SECS_DEF,
  parameter int unsigned MAX_LEVEL   = MAX_LEVEL_DEF
) (
  input logic                   Clk100M,
  input logic                   reset,
  game_phase_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic               load;
  logic [SECS_W-1:0]  load_val;
  logic               level_inc;
  logic               restart;
  logic               expire;
  logic [SECS_W-1:0]  secs;
  logic [LEVEL_W-1:0] level_q;
  logic               prelim_q, answer_q, post_q, level_chng_q, period_start_q, game_over_q;

  period_timer u_timer (
    .clk      (Clk100M),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (bus.Clk1Hz),
    .count    (secs),
    .expire   (expire)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_val  = '0;
    level_inc = 1'b0;
    restart   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StPrelim;
          load     = 1'b1;
          load_val = SECS_W'(PRELIM_SECS);
          restart  = 1'b1;
        end
      end
      StPrelim: begin
        if (expire) begin
          state_d  = StPlay;
          load     = 1'b1;
          load_val = SECS_W'(PLAY_SECS);
        end
      end
      StPlay: begin
        if (expire) begin
          state_d  = StAnswer;
          load     = 1'b1;
          load_val = SECS_W'(ANSWER_SECS);
        end
      end
      StAnswer: begin
        // Submit and expiry coinciding still produce a single entry into POST.
        if (bus.answerSubmit || expire) begin
          state_d  = StPost;
          load     = 1'b1;
          load_val = SECS_W'(POST_SECS);
        end
      end
      StPost: begin
        if (expire) begin
          load = 1'b1;
          if (level_q < LEVEL_W'(MAX_LEVEL)) begin
            state_d   = StPlay;
            load_val  = SECS_W'(PLAY_SECS);
            level_inc = 1'b1;
          end else begin
            state_d  = StDone;
            load_val = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state_q        <= StIdle;
      level_q        <= LEVEL_W'(1);
      prelim_q       <= 1'b0;
      answer_q       <= 1'b0;
      post_q         <= 1'b0;
      level_chng_q   <= 1'b0;
      period_start_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        level_q <= LEVEL_W'(1);
      end else if (level_inc) begin
        level_q <= level_q + LEVEL_W'(1);
      end
      prelim_q       <= (state_d == StPrelim);
      answer_q       <= (state_d == StAnswer);
      post_q         <= (state_d == StPost);
      level_chng_q   <= level_inc;
      // DONE is not a timed period, so its zero load does not count as a period start.
      period_start_q <= load && (state_d != StDone);
      game_over_q    <= (state_d == StDone);
    end
  end

  assign bus.prelimPeriod = prelim_q;
  assign bus.answerPeriod = answer_q;
  assign bus.postPeriod   = post_q;
  assign bus.levelChng    = level_chng_q;
  assign bus.level        = level_q;
  assign bus.secondsLeft  = secs;
  assign bus.periodStart  = period_start_q;
  assign bus.gameOver     = game_over_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer: directed vector table, hand sequences and random vs a model.
module tb_game_phase_sequencer;

  localparam int PRELIM = 2;
  localparam int PLAY   = 3;
  localparam int ANSWER = 5;
  localparam int POST   = 4;
  localparam int MAXLVL = 3;

  localparam int PH_IDLE   = 0;
  localparam int PH_PRELIM = 1;
  localparam int PH_PLAY   = 2;
  localparam int PH_ANSWER = 3;
  localparam int PH_POST   = 4;
  localparam int PH_DONE   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_phase_sequencer_if bus ();

  game_phase_sequencer #(
    .PRELIM_SECS (PRELIM),
    .PLAY_SECS   (PLAY),
    .ANSWER_SECS (ANSWER),
    .POST_SECS   (POST),
    .MAX_LEVEL   (MAXLVL)
  ) dut (
    .Clk100M (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int lchg_seen = 0;

  // Reference model: phase index, ticks remaining, level, one-cycle pulses.
  int m_phase = PH_IDLE;
  int m_secs  = 0;
  int m_level = 1;
  bit m_lchg  = 1'b0;
  bit m_pstart = 1'b0;

  function automatic int dur(input int p);
    case (p)
      PH_PRELIM: return PRELIM;
      PH_PLAY:   return PLAY;
      PH_ANSWER: return ANSWER;
      PH_POST:   return POST;
      default:   return 0;
    endcase
  endfunction

  task automatic model_enter(input int p);
    m_phase  = p;
    m_secs   = dur(p);
    m_pstart = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit s, input bit t, input bit a);
    m_lchg   = 1'b0;
    m_pstart = 1'b0;
    if (r) begin
      m_phase = PH_IDLE;
      m_level = 1;
      m_secs  = 0;
    end else if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
      if (s) begin
        model_enter(PH_PRELIM);
        m_level = 1;
      end
    end else if (m_phase == PH_ANSWER && a) begin
      model_enter(PH_POST);
    end else if (t) begin
      if (m_secs > 1) m_secs--;
      else if (m_phase != PH_POST) model_enter(m_phase + 1);
      else if (m_level < MAXLVL) begin
        m_level++;
        m_lchg = 1'b1;
        model_enter(PH_PLAY);
      end else begin
        m_phase = PH_DONE;
        m_secs  = 0;
      end
    end
  endtask

  function automatic logic [16:0] pack(input bit pre, input bit ans, input bit post, input bit go,
                                       input bit lc, input bit ps, input int lvl, input int secs);
    return {pre, ans, post, go, lc, ps, 5'(lvl), 6'(secs)};
  endfunction

  function automatic logic [16:0] model_vec();
    return pack(m_phase == PH_PRELIM, m_phase == PH_ANSWER, m_phase == PH_POST,
                m_phase == PH_DONE, m_lchg, m_pstart, m_level, m_secs);
  endfunction

  function automatic logic [16:0] dut_vec();
    return {bus.prelimPeriod, bus.answerPeriod, bus.postPeriod, bus.gameOver, bus.levelChng,
            bus.periodStart, bus.level, bus.secondsLeft};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs are applied 1 time unit after an edge and outputs sampled 1 unit after the next.
  task automatic step(input bit r, input bit s, input bit t, input bit a);
    rst              = r;
    bus.start        = s;
    bus.Clk1Hz       = t;
    bus.answerSubmit = a;
    @(posedge clk);
    model_step(r, s, t, a);
    #1;
    check("model", 32'(dut_vec()), 32'(model_vec()));
    if (bus.levelChng === 1'b1) lchg_seen++;
  endtask

  typedef struct {
    bit          r, s, t, a;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input bit r, input bit s, input bit t, input bit a,
                              input logic [16:0] e);
    vec_t v;
    v.r = r; v.s = s; v.t = t; v.a = a; v.exp = e;
    return v;
  endfunction

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.Clk1Hz = 1'b0;
    bus.answerSubmit = 1'b0;

    //                r  s  t  a        pre ans post go lc ps lvl secs
    vecs[0]  = mk(1, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 1, 0));
    vecs[1]  = mk(0, 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 1, 0));
    vecs[2]  = mk(0, 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 1, 0));
    vecs[3]  = mk(0, 1, 1, 0, pack(1, 0, 0, 0, 0, 1, 1, 2));  // tick at entry ignored
    vecs[4]  = mk(0, 1, 0, 0, pack(1, 0, 0, 0, 0, 0, 1, 2));
    vecs[5]  = mk(0, 0, 1, 0, pack(1, 0, 0, 0, 0, 0, 1, 1));
    vecs[6]  = mk(0, 0, 1, 0, pack(0, 0, 0, 0, 0, 1, 1, 3));
    vecs[7]  = mk(0, 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 1, 3));  // submit in PLAY ignored
    vecs[8]  = mk(0, 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 1, 2));
    vecs[9]  = mk(0, 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 1, 1));
    vecs[10] = mk(0, 0, 1, 0, pack(0, 1, 0, 0, 0, 1, 1, 5));
    vecs[11] = mk(0, 0, 1, 0, pack(0, 1, 0, 0, 0, 0, 1, 4));
    vecs[12] = mk(0, 0, 1, 0, pack(0, 1, 0, 0, 0, 0, 1, 3));
    vecs[13] = mk(0, 0, 1, 0, pack(0, 1, 0, 0, 0, 0, 1, 2));
    vecs[14] = mk(0, 0, 1, 1, pack(0, 0, 1, 0, 0, 1, 1, 4));  // submit beats tick
    vecs[15] = mk(0, 0, 0, 0, pack(0, 0, 1, 0, 0, 0, 1, 4));
    vecs[16] = mk(0, 0, 1, 0, pack(0, 0, 1, 0, 0, 0, 1, 3));
    vecs[17] = mk(0, 0, 1, 0, pack(0, 0, 1, 0, 0, 0, 1, 2));
    vecs[18] = mk(0, 0, 1, 0, pack(0, 0, 1, 0, 0, 0, 1, 1));
    vecs[19] = mk(0, 0, 1, 0, pack(0, 0, 0, 0, 1, 1, 2, 3));  // level advance
    vecs[20] = mk(0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 2, 3));
    vecs[21] = mk(0, 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 2, 2));
    vecs[22] = mk(0, 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 2, 1));
    vecs[23] = mk(0, 0, 1, 0, pack(0, 1, 0, 0, 0, 1, 2, 5));
    vecs[24] = mk(1, 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 1, 0));  // reset mid-ANSWER
    vecs[25] = mk(0, 0, 1, 1, pack(0, 0, 0, 0, 0, 0, 1, 0));

    #1;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].t, vecs[i].a);
      check($sformatf("vec[%0d]", i), 32'(dut_vec()), 32'(vecs[i].exp));
    end

    // Full game with no submits: ANSWER expires by timeout, last POST ends in DONE.
    step(1, 0, 0, 0);
    lchg_seen = 0;
    step(0, 1, 0, 0);
    for (int i = 0; i < PRELIM + (PLAY + ANSWER + POST) * MAXLVL - 1; i++) step(0, 0, 1, 0);
    check("last_post", 32'(dut_vec()), 32'(pack(0, 0, 1, 0, 0, 0, MAXLVL, 1)));
    step(0, 0, 1, 0);
    check("done", 32'(dut_vec()), 32'(pack(0, 0, 0, 1, 0, 0, MAXLVL, 0)));
    check("lchg_count", 32'(lchg_seen), 32'(MAXLVL - 1));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    check("done_hold", 32'(dut_vec()), 32'(pack(0, 0, 0, 1, 0, 0, MAXLVL, 0)));
    step(0, 1, 1, 0);
    check("restart", 32'(dut_vec()), 32'(pack(1, 0, 0, 0, 0, 1, 1, PRELIM)));
    check("lchg_restart", 32'(lchg_seen), 32'(MAXLVL - 1));

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_phase_sequencer.md
Name: game_phase_sequencer

Overview:
- Game-flow controller and consumer of the tick pulses from the clock/tick generator.
- Walks the game through its periods: preliminary countdown, symbol play, answer entry and post-level result. Each period is timed in 1 Hz ticks.
- Drives the period flags, the level number and the level-change pulse back into the tick generator.
- Provides a seconds-remaining value for the 7-segment display path.

Parameters:
- PRELIM_SECS, 3, preliminary countdown length in ticks (>=1)
- PLAY_SECS, 20, symbol-play period length in ticks (>=1)
- ANSWER_SECS, 10, answer-entry period length in ticks (>=1)
- POST_SECS, 3, result-display period length in ticks (>=1)
- MAX_LEVEL, 10, last level; 1..19 so level*5e6 stays below the 1e8 SymGen base

Ports:
- Clk100M  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- start  in  1  level-sensitive start request, sampled on Clk100M
- Clk1Hz  in  1  one-cycle 1 Hz tick pulse from the tick generator
- answerSubmit  in  1  one-cycle pulse; player finished entering the answer
- prelimPeriod  out  1  high during PRELIM
- answerPeriod  out  1  high during ANSWER
- postPeriod  out  1  high during POST
- levelChng  out  1  one-cycle pulse when level advances
- level  out  5  current level, 1..MAX_LEVEL
- secondsLeft  out  6  remaining ticks in current period
- periodStart  out  1  one-cycle pulse on every period entry (restarts the 1 Hz counter)
- gameOver  out  1  high in DONE

Behaviour:
- States: IDLE, PRELIM, PLAY, ANSWER, POST, DONE. Outputs are registered and decoded from state.
- Reset, synchronous, highest priority: state=IDLE, level=1, secondsLeft=0, all flags and pulses 0.
- IDLE: start=1 -> PRELIM, level=1.
- DONE: gameOver=1. start=1 -> PRELIM, level=1.
- start is ignored in every other state.
- Period entry, same edge as the transition:
  - secondsLeft loads the period's *_SECS.
  - periodStart=1 for exactly that one cycle.
- Countdown: on a cycle with Clk1Hz=1 inside a timed state:
  - secondsLeft>1: decrement.
  - secondsLeft==1: transition. A period therefore lasts exactly N ticks.
- Transitions on expiry:
  - PRELIM -> PLAY
  - PLAY -> ANSWER
  - ANSWER -> POST
  - POST -> PLAY with level+1, if level<MAX_LEVEL
  - POST -> DONE, if level==MAX_LEVEL
- answerSubmit in ANSWER: -> POST on the next edge, regardless of secondsLeft. Ignored in all other states.
- answerSubmit and Clk1Hz in the same cycle in ANSWER: submit wins. Go to POST once; never skip POST.
- levelChng:
  - High for one cycle, on the same edge that level increments (POST->PLAY).
  - level already holds the new value in that cycle.
  - Never asserted on the IDLE/DONE->PRELIM level=1 load.
- level never exceeds MAX_LEVEL and never wraps.
- Flag exclusivity: at most one of prelimPeriod/answerPeriod/postPeriod is high. All three are low in IDLE, PLAY and DONE.
- secondsLeft is 0 in IDLE and DONE.
- Clk1Hz in the same cycle as a state entry is ignored; the countdown begins on the next tick.
- Reset mid-period: next cycle is IDLE with all outputs at reset values, even if levelChng or periodStart would have fired.

Decomposition:
- Shared package game_pkg:
  - state enum encoding
  - LEVEL_W=5, SECS_W=6
  - the default period durations, so the display and score blocks share the constants
- One sub-module: period_timer, the loadable down-counter with tick-enable.
  - Inputs: load, load value, tick.
  - Outputs: count, expire pulse.
  - The FSM instantiates a single copy.

Test Plan:
- Reset then start=1, all *_SECS=2 -> periodStart pulse, prelimPeriod=1, secondsLeft=2; after 2 ticks PLAY with all flags 0.
- Run level 1 to POST expiry -> levelChng one cycle, level=2 in that cycle, state PLAY, secondsLeft=2.
- In ANSWER with secondsLeft=2, pulse answerSubmit together with Clk1Hz -> POST next cycle, postPeriod=1, secondsLeft=POST_SECS, single periodStart.
- MAX_LEVEL=2, play through both levels -> after level-2 POST, gameOver=1, level stays 2, no levelChng; start -> PRELIM, level=1, no levelChng.
- Assert reset during ANSWER with secondsLeft=5 -> next cycle IDLE, level=1, all outputs 0; answerSubmit in IDLE/PLAY has no effect.
- Tick coincident with PRELIM entry -> secondsLeft stays PRELIM_SECS; period still lasts PRELIM_SECS subsequent ticks.
